// File: rtl/uart_msg_echo_pkg.sv
// uart_msg_echo_pkg: sequencer state encodings, mode bit indices and shared defaults
package uart_msg_echo_pkg;
  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_BANNER = 2'd1;
  localparam logic [1:0] ST_ECHO   = 2'd2;
  localparam int MODE_BANNER = 0;
  localparam int MODE_ECHO   = 1;
  localparam int DEF_CLK_FRE = 27;
  typedef logic [7:0] byte_t;
  function automatic byte_t sat_inc(input byte_t v);
    return (v == 8'hff) ? v : v + 8'd1;
  endfunction
endpackage

// File: rtl/uart_byte_fifo.sv
// uart_byte_fifo: power-of-two FIFO with wrap-bit pointers and registered read data
module uart_byte_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);
  localparam int AW = $clog2(DEPTH);
  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0] wr_q, wr_d, rd_q, rd_d;
  logic [WIDTH-1:0] rdata_q, rdata_d;
  logic do_push, do_pop;
  always_comb begin
    full = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
    empty = wr_q == rd_q;
    do_pop = pop & !empty;
    do_push = push & (!full | do_pop);
    wr_d = wr_q + (AW+1)'(do_push);
    rd_d = rd_q + (AW+1)'(do_pop);
    rdata_d = do_pop ? mem[rd_q[AW-1:0]] : rdata_q;
    rdata = rdata_q;
  end
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_q[AW-1:0]] <= wdata;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_q <= '0;
      rd_q <= '0;
      rdata_q <= '0;
    end else begin
      wr_q <= wr_d;
      rd_q <= rd_d;
      rdata_q <= rdata_d;
    end
  end
endmodule

// File: rtl/uart_msg_echo.sv
// uart_msg_echo: sends a periodic banner and echoes queued RX bytes over a valid/ready TX port
module uart_msg_echo
  import uart_msg_echo_pkg::*;
#(
  parameter int                   CLK_FRE    = DEF_CLK_FRE,
  parameter int                   PERIOD_MS  = 1000,
  parameter int                   MSG_LEN    = 21,
  parameter logic [MSG_LEN*8-1:0] MSG        = "Hello Tang Nano 20K\r\n",
  parameter int                   FIFO_DEPTH = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] mode,
  input  logic [7:0] rx_data,
  input  logic       rx_data_valid,
  output logic       rx_data_ready,
  output logic [7:0] tx_data,
  output logic       tx_data_valid,
  input  logic       tx_data_ready,
  output logic       busy,
  output logic [7:0] drop_cnt
);
  localparam int LIMIT = CLK_FRE * 1000 * PERIOD_MS - 1;
  localparam int CW = $clog2(LIMIT + 1);
  logic [CW-1:0] cnt_q, cnt_d;
  logic [1:0] state_q, state_d;
  byte_t idx_q, idx_d, nidx, tx_data_q, tx_data_d, drop_q, drop_d, fifo_rdata, msg_byte;
  logic tx_valid_q, tx_valid_d, pend_q, pend_d, rdy_q;
  logic tick, accept, last, push, pop, fifo_full, fifo_empty;
  uart_byte_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .wdata (rx_data),
    .pop   (pop),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty)
  );
  always_comb begin
    tick = cnt_q == CW'(LIMIT);
    cnt_d = tick ? '0 : cnt_q + 1'b1;
    accept = tx_valid_q & tx_data_ready;
    last = idx_q == 8'(MSG_LEN - 1);
    nidx = (state_q == ST_BANNER && !last) ? idx_q + 8'd1 : 8'd0;
    msg_byte = MSG[(MSG_LEN - 1 - int'(nidx)) * 8 +: 8];
    push = rx_data_valid & mode[MODE_ECHO];
    state_d = state_q;
    idx_d = idx_q;
    pop = 1'b0;
    tx_data_d = tx_data_q;
    tx_valid_d = tx_valid_q & !tx_data_ready;
    // a tick outside IDLE is remembered once; IDLE consumes or discards it
    pend_d = pend_q | (tick & mode[MODE_BANNER]);
    if (state_q == ST_IDLE) begin
      pend_d = 1'b0;
      if ((tick | pend_q) & mode[MODE_BANNER]) begin
        state_d = ST_BANNER;
        idx_d = '0;
        tx_data_d = msg_byte;
        tx_valid_d = 1'b1;
      end else if (mode[MODE_ECHO] & !fifo_empty) begin
        state_d = ST_ECHO;
        pop = 1'b1;
      end
    end else if (state_q == ST_BANNER) begin
      if (accept & last) state_d = ST_IDLE;
      else if (accept) begin
        idx_d = nidx;
        tx_data_d = msg_byte;
        tx_valid_d = 1'b1;
      end
    end else if (!tx_valid_q) begin
      tx_data_d = fifo_rdata;
      tx_valid_d = 1'b1;
    end else if (accept) state_d = ST_IDLE;
    drop_d = (push & fifo_full & !pop) ? sat_inc(drop_q) : drop_q;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cnt_q <= '0;
      idx_q <= '0;
      pend_q <= 1'b0;
      tx_data_q <= '0;
      tx_valid_q <= 1'b0;
      drop_q <= '0;
      rdy_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      idx_q <= idx_d;
      pend_q <= pend_d;
      tx_data_q <= tx_data_d;
      tx_valid_q <= tx_valid_d;
      drop_q <= drop_d;
      rdy_q <= 1'b1;
    end
  end
  assign rx_data_ready = rdy_q;
  assign tx_data = tx_data_q;
  assign tx_data_valid = tx_valid_q;
  assign busy = state_q != ST_IDLE;
  assign drop_cnt = drop_q;
endmodule

// File: tb/tb_uart_msg_echo.sv
// tb_uart_msg_echo: scenario tasks checked against a transaction-level model of the sequencer
module tb_uart_msg_echo;
  localparam int MLEN = 21;
  localparam int PER = 1000;
  localparam int DEPTH = 4;
  logic clk = 1'b0, rst_n = 1'b0;
  logic [1:0] mode = 2'b00;
  logic [7:0] rx_data = 8'h00;
  logic rx_data_valid = 1'b0, tx_data_ready = 1'b0;
  logic rx_data_ready, tx_data_valid, busy;
  logic [7:0] tx_data, drop_cnt;
  uart_msg_echo #(.CLK_FRE(1), .PERIOD_MS(1), .MSG_LEN(MLEN), .FIFO_DEPTH(DEPTH)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .mode          (mode),
    .rx_data       (rx_data),
    .rx_data_valid (rx_data_valid),
    .rx_data_ready (rx_data_ready),
    .tx_data       (tx_data),
    .tx_data_valid (tx_data_valid),
    .tx_data_ready (tx_data_ready),
    .busy          (busy),
    .drop_cnt      (drop_cnt)
  );
  always #5 clk = ~clk;
  int n_cmp = 0, n_bad = 0, stab_err = 0, rdy_mode = 0;
  int unsigned cyc = 0;
  logic [7:0] got[$];
  int unsigned got_cyc[$];
  logic pv_wait = 1'b0;
  logic [7:0] pv_data = 8'h00;
  string ban = "Hello Tang Nano 20K\r\n";
  always @(posedge clk) cyc <= cyc + 1;
  // the TX side is observed mid-cycle: valid&ready here means the byte is taken at the next edge
  always @(negedge clk) begin
    if (!rst_n) pv_wait = 1'b0;
    else begin
      if (pv_wait && (!tx_data_valid || tx_data !== pv_data)) stab_err++;
      if (tx_data_valid && tx_data_ready) begin
        got.push_back(tx_data);
        got_cyc.push_back(cyc);
      end
      pv_wait = tx_data_valid && !tx_data_ready;
      pv_data = tx_data;
    end
  end
  initial forever begin
    @(posedge clk);
    #1;
    tx_data_ready = rdy_mode == 0 ? 1'b1 : rdy_mode == 1 ? ($urandom_range(0, 9) == 0) : 1'b0;
  end
  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1);
  end
  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask
  task automatic send(input logic [7:0] b);
    rx_data = b;
    rx_data_valid = 1'b1;
    step(1);
    rx_data_valid = 1'b0;
  endtask
  task automatic wait_got(input int n, input int budget, output bit ok);
    int k = 0;
    while (got.size() < n && k < budget) begin
      step(1);
      k++;
    end
    ok = got.size() >= n;
  endtask
  task automatic wait_valid(input int budget, output bit ok);
    int k = 0;
    while (!tx_data_valid && k < budget) begin
      step(1);
      k++;
    end
    ok = tx_data_valid;
  endtask
  task automatic wait_idle(input int budget, output bit ok);
    int k = 0;
    while ((busy || tx_data_valid) && k < budget) begin
      step(1);
      k++;
    end
    ok = !busy && !tx_data_valid;
  endtask
  task automatic test_reset;
    rst_n = 1'b0;
    rdy_mode = 2;
    step(3);
    n_cmp++; if ({tx_data_valid, busy, rx_data_ready} !== 3'b000) begin n_bad++; $display("FAIL reset_flags: got %b want 000", {tx_data_valid, busy, rx_data_ready}); end
    n_cmp++; if (tx_data !== 8'h00) begin n_bad++; $display("FAIL reset_tx_data: got %h want 00", tx_data); end
    n_cmp++; if (drop_cnt !== 8'h00) begin n_bad++; $display("FAIL reset_drop: got %0d want 0", drop_cnt); end
    rst_n = 1'b1;
    step(2);
    n_cmp++; if (rx_data_ready !== 1'b1) begin n_bad++; $display("FAIL rx_ready_after_reset: got %b want 1", rx_data_ready); end
    n_cmp++; if (tx_data_valid !== 1'b0) begin n_bad++; $display("FAIL idle_valid: got %b want 0", tx_data_valid); end
  endtask
  task automatic test_banner;
    bit ok;
    mode = 2'b01;
    rdy_mode = 0;
    got.delete();
    got_cyc.delete();
    wait_got(2 * MLEN, 2 * PER + 200, ok);
    n_cmp++; if (!ok) begin n_bad++; $display("FAIL banner_timeout: got %0d bytes want %0d", got.size(), 2 * MLEN); end
    for (int i = 0; i < got.size() && i < 2 * MLEN; i++) begin
      n_cmp++; if (got[i] !== ban[i % MLEN]) begin n_bad++; $display("FAIL banner_byte[%0d]: got %h want %h", i, got[i], ban[i % MLEN]); end
    end
    if (ok) begin
      n_cmp++; if (int'(got_cyc[MLEN] - got_cyc[0]) !== PER) begin n_bad++; $display("FAIL banner_period: got %0d want %0d", got_cyc[MLEN] - got_cyc[0], PER); end
      n_cmp++; if (int'(got_cyc[MLEN-1] - got_cyc[0]) !== MLEN - 1) begin n_bad++; $display("FAIL banner_burst: got %0d want %0d", got_cyc[MLEN-1] - got_cyc[0], MLEN - 1); end
    end
    rdy_mode = 1;
    got.delete();
    wait_got(5, 2 * PER, ok);
    n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL busy_in_banner: got %b want 1", busy); end
    wait_got(MLEN, 2 * PER, ok);
    n_cmp++; if (!ok) begin n_bad++; $display("FAIL slow_banner_timeout: got %0d want %0d", got.size(), MLEN); end
    for (int i = 0; i < got.size() && i < MLEN; i++) begin
      n_cmp++; if (got[i] !== ban[i]) begin n_bad++; $display("FAIL slow_banner_byte[%0d]: got %h want %h", i, got[i], ban[i]); end
    end
    n_cmp++; if (stab_err !== 0) begin n_bad++; $display("FAIL banner_stability: got %0d violations want 0", stab_err); end
  endtask
  task automatic test_echo;
    bit ok;
    logic [7:0] exp[$];
    wait_idle(2 * PER, ok);
    mode = 2'b10;
    rdy_mode = 2;
    step(2);
    got.delete();
    send(8'h5a);
    @(negedge clk);
    @(negedge clk);
    n_cmp++; if (tx_data_valid !== 1'b0) begin n_bad++; $display("FAIL echo_latency_early: got %b want 0", tx_data_valid); end
    @(negedge clk);
    n_cmp++; if ({tx_data_valid, tx_data} !== {1'b1, 8'h5a}) begin n_bad++; $display("FAIL echo_latency: got %b/%h want 1/5a", tx_data_valid, tx_data); end
    rdy_mode = 0;
    step(4);
    rdy_mode = 2;
    step(2);
    got.delete();
    exp = '{8'h41, 8'h42, 8'h43};
    foreach (exp[i]) send(exp[i]);
    step(50);
    n_cmp++; if ({tx_data_valid, tx_data} !== {1'b1, 8'h41} || got.size() != 0) begin n_bad++; $display("FAIL echo_hold: got %b/%h n=%0d want 1/41 n=0", tx_data_valid, tx_data, got.size()); end
    rdy_mode = 0;
    wait_got(3, 100, ok);
    n_cmp++; if (!ok) begin n_bad++; $display("FAIL echo_timeout: got %0d want 3", got.size()); end
    for (int i = 0; i < got.size() && i < 3; i++) begin
      n_cmp++; if (got[i] !== exp[i]) begin n_bad++; $display("FAIL echo_order[%0d]: got %h want %h", i, got[i], exp[i]); end
    end
    n_cmp++; if (stab_err !== 0) begin n_bad++; $display("FAIL echo_stability: got %0d violations want 0", stab_err); end
  endtask
  task automatic test_random_echo;
    bit ok;
    int bad = 0;
    logic [7:0] exp[$];
    logic [7:0] b;
    mode = 2'b10;
    rdy_mode = 1;
    got.delete();
    // never more than DEPTH-1 bytes outstanding, so no byte may be dropped
    while (exp.size() < 40) begin
      if (exp.size() - got.size() < DEPTH - 1) begin
        b = 8'($urandom);
        exp.push_back(b);
        send(b);
        step($urandom_range(0, 3));
      end else step(1);
    end
    wait_got(40, 2000, ok);
    n_cmp++; if (!ok) begin n_bad++; $display("FAIL random_echo_timeout: got %0d want 40", got.size()); end
    for (int i = 0; i < got.size() && i < 40; i++) if (got[i] !== exp[i]) bad++;
    n_cmp++; if (bad != 0) begin n_bad++; $display("FAIL random_echo_data: got %0d wrong bytes want 0", bad); end
    n_cmp++; if (drop_cnt !== 8'd0) begin n_bad++; $display("FAIL random_echo_drop: got %0d want 0", drop_cnt); end
  endtask
  task automatic test_drop;
    bit ok;
    int bad = 0;
    logic [7:0] exp[$];
    wait_idle(2 * PER, ok);
    mode = 2'b11;
    rdy_mode = 0;
    got.delete();
    wait_valid(PER + 100, ok);
    n_cmp++; if (!ok) begin n_bad++; $display("FAIL drop_banner_start: got valid=%b want 1", tx_data_valid); end
    for (int i = 0; i < 6; i++) begin
      exp.push_back(8'($urandom));
      send(exp[i]);
    end
    step(1);
    n_cmp++; if (drop_cnt !== 8'd2) begin n_bad++; $display("FAIL drop_count: got %0d want 2", drop_cnt); end
    wait_got(MLEN + DEPTH, 200, ok);
    step(20);
    n_cmp++; if (got.size() != MLEN + DEPTH) begin n_bad++; $display("FAIL drop_echo_count: got %0d want %0d", got.size(), MLEN + DEPTH); end
    for (int i = 0; i < got.size() && i < MLEN + DEPTH; i++)
      if (got[i] !== (i < MLEN ? ban[i] : exp[i - MLEN])) bad++;
    n_cmp++; if (bad != 0) begin n_bad++; $display("FAIL drop_echo_data: got %0d wrong bytes want 0", bad); end
    mode = 2'b10;
    rdy_mode = 2;
    step(2);
    got.delete();
    exp.delete();
    for (int i = 0; i < 300; i++) begin
      exp.push_back(8'($urandom));
      send(exp[i]);
    end
    step(2);
    n_cmp++; if (drop_cnt !== 8'd255) begin n_bad++; $display("FAIL drop_saturate: got %0d want 255", drop_cnt); end
    rdy_mode = 0;
    wait_got(DEPTH + 1, 100, ok);
    step(20);
    n_cmp++; if (got.size() != DEPTH + 1) begin n_bad++; $display("FAIL sat_retained: got %0d want %0d", got.size(), DEPTH + 1); end
    bad = 0;
    for (int i = 0; i < got.size() && i < DEPTH + 1; i++) if (got[i] !== exp[i]) bad++;
    n_cmp++; if (bad != 0) begin n_bad++; $display("FAIL sat_echo_data: got %0d wrong bytes want 0", bad); end
    mode = 2'b00;
    for (int i = 0; i < 5; i++) send(8'($urandom));
    mode = 2'b10;
    step(20);
    n_cmp++; if (got.size() != DEPTH + 1 || drop_cnt !== 8'd255) begin n_bad++; $display("FAIL ignore_rx: got n=%0d drop=%0d want n=%0d drop=255", got.size(), drop_cnt, DEPTH + 1); end
  endtask
  task automatic test_pend;
    bit ok;
    int bad = 0;
    wait_idle(2 * PER, ok);
    mode = 2'b01;
    rdy_mode = 2;
    step(2);
    got.delete();
    got_cyc.delete();
    wait_valid(PER + 100, ok);
    n_cmp++; if (!ok) begin n_bad++; $display("FAIL pend_banner_start: got valid=%b want 1", tx_data_valid); end
    step(3100);
    n_cmp++; if ({tx_data_valid, tx_data} !== {1'b1, ban[0]} || stab_err !== 0) begin n_bad++; $display("FAIL pend_hold: got %b/%h err=%0d want 1/%h err=0", tx_data_valid, tx_data, stab_err, ban[0]); end
    rdy_mode = 0;
    step(400);
    n_cmp++; if (got.size() != 2 * MLEN) begin n_bad++; $display("FAIL pend_count: got %0d want %0d", got.size(), 2 * MLEN); end
    for (int i = 0; i < got.size() && i < 2 * MLEN; i++) if (got[i] !== ban[i % MLEN]) bad++;
    n_cmp++; if (bad != 0) begin n_bad++; $display("FAIL pend_data: got %0d wrong bytes want 0", bad); end
    if (got.size() > MLEN) begin
      n_cmp++; if (int'(got_cyc[MLEN] - got_cyc[MLEN-1]) > 2) begin n_bad++; $display("FAIL pend_gap: got %0d want <=2", got_cyc[MLEN] - got_cyc[MLEN-1]); end
    end
    n_cmp++; if (tx_data_valid !== 1'b0) begin n_bad++; $display("FAIL pend_once: got valid=%b want 0", tx_data_valid); end
  endtask
  task automatic test_reset_mid;
    bit ok;
    int bad = 0;
    int unsigned t_rel;
    wait_idle(2 * PER, ok);
    mode = 2'b11;
    rdy_mode = 0;
    got.delete();
    got_cyc.delete();
    wait_got(3, PER + 100, ok);
    send(8'h11);
    send(8'h22);
    wait_got(7, 50, ok);
    n_cmp++; if (got.size() != 7) begin n_bad++; $display("FAIL mid_idx: got %0d bytes want 7", got.size()); end
    rst_n = 1'b0;
    #1;
    n_cmp++; if ({tx_data_valid, busy, rx_data_ready, tx_data, drop_cnt} !== 19'd0) begin n_bad++; $display("FAIL mid_reset_outputs: got v=%b b=%b r=%b d=%h c=%0d want all 0", tx_data_valid, busy, rx_data_ready, tx_data, drop_cnt); end
    step(2);
    rst_n = 1'b1;
    t_rel = cyc;
    got.delete();
    got_cyc.delete();
    wait_got(MLEN, PER + 100, ok);
    step(50);
    n_cmp++; if (got.size() != MLEN) begin n_bad++; $display("FAIL post_reset_count: got %0d want %0d", got.size(), MLEN); end
    for (int i = 0; i < got.size() && i < MLEN; i++) if (got[i] !== ban[i]) bad++;
    n_cmp++; if (bad != 0) begin n_bad++; $display("FAIL post_reset_data: got %0d wrong bytes want 0", bad); end
    if (got.size() > 0) begin
      n_cmp++; if (int'(got_cyc[0] - t_rel) !== PER) begin n_bad++; $display("FAIL post_reset_tick: got %0d want %0d", got_cyc[0] - t_rel, PER); end
    end
  endtask
  task automatic test_mode_switch;
    bit ok;
    logic [7:0] exp[$];
    wait_idle(2 * PER, ok);
    mode = 2'b11;
    rdy_mode = 1;
    got.delete();
    wait_valid(PER + 100, ok);
    for (int i = 0; i < 3; i++) begin
      exp.push_back(8'($urandom));
      send(exp[i]);
    end
    mode = 2'b00;
    wait_got(MLEN, 1500, ok);
    step(1200);
    n_cmp++; if (got.size() != MLEN || busy !== 1'b0 || tx_data_valid !== 1'b0) begin n_bad++; $display("FAIL mode_off: got n=%0d busy=%b v=%b want n=%0d busy=0 v=0", got.size(), busy, tx_data_valid, MLEN); end
    mode = 2'b10;
    wait_got(MLEN + 3, 300, ok);
    n_cmp++; if (!ok) begin n_bad++; $display("FAIL mode_restore_timeout: got %0d want %0d", got.size(), MLEN + 3); end
    for (int i = 0; i < 3 && MLEN + i < got.size(); i++) begin
      n_cmp++; if (got[MLEN + i] !== exp[i]) begin n_bad++; $display("FAIL mode_restore_echo[%0d]: got %h want %h", i, got[MLEN + i], exp[i]); end
    end
  endtask
  initial begin
    test_reset;
    test_banner;
    test_echo;
    test_random_echo;
    test_drop;
    test_pend;
    test_reset_mid;
    test_mode_switch;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
